// File: rtl/lfsr_gen.sv
// rtl/lfsr_gen.sv - parametrised Fibonacci/Galois LFSR with seed load and zero-seed protection
// Optional period-measurement counter enabled by defining LFSR_PERIOD_CHECK_EN.
module lfsr_gen #(
  parameter int          N          = 20,
  parameter logic [N-1:0] POLY       = 20'h90000,
  parameter bit          GALOIS     = 1'b0,
  parameter logic [N-1:0] RESET_SEED = {{(N-1){1'b0}}, 1'b1}
) (
  input  logic         clk,
  input  logic         r,
  input  logic         load,
  input  logic [N-1:0] seed,
  input  logic         en,
  output logic [N-1:0] q,
  output logic [N-1:0] qbar,
  output logic         out_bit,
  output logic         seed_err,
  output logic         period_done,
  output logic [N-1:0] period
);

  localparam logic [N-1:0] ONE   = {{(N-1){1'b0}}, 1'b1};
  localparam logic [N-1:0] GMASK = {POLY[N-2:0], 1'b1};

  logic [N-1:0] step_val;
  logic [N-1:0] load_val;
  logic         seed_zero;

  generate
    if (GALOIS) begin : g_galois
      always_comb begin
        step_val = {q[N-2:0], 1'b0} ^ ({N{q[N-1]}} & GMASK);
      end
    end else begin : g_fibonacci
      always_comb begin
        step_val = {q[N-2:0], ^(q & POLY)};
      end
    end
  endgenerate

  // An all-zero seed would lock the register up, so it is replaced by 1.
  assign seed_zero = (seed == '0);
  assign load_val  = seed_zero ? ONE : seed;

  always_ff @(posedge clk) begin
    seed_err <= 1'b0;
    if (r) begin
      q    <= RESET_SEED;
      qbar <= ~RESET_SEED;
    end else if (load) begin
      q        <= load_val;
      qbar     <= ~load_val;
      seed_err <= seed_zero;
    end else if (en) begin
      q    <= step_val;
      qbar <= ~step_val;
    end
  end

  assign out_bit = q[N-1];

`ifdef LFSR_PERIOD_CHECK_EN
  logic [N-1:0] cnt;
  logic [N-1:0] seed_reg;
  logic         cnt_sat;

  assign cnt_sat = (cnt == '1);

  always_ff @(posedge clk) begin
    period_done <= 1'b0;
    if (r) begin
      cnt      <= '0;
      seed_reg <= RESET_SEED;
      period   <= '0;
    end else if (load) begin
      cnt      <= '0;
      seed_reg <= load_val;
    end else if (en) begin
      if (step_val == seed_reg) begin
        period_done <= 1'b1;
        period      <= cnt_sat ? cnt : cnt + ONE;
        cnt         <= '0;
      end else if (!cnt_sat) begin
        cnt <= cnt + ONE;
      end
    end
  end
`else
  assign period_done = 1'b0;
  assign period      = '0;
`endif

endmodule

// File: tb/tb_lfsr_gen.sv
// tb/tb_lfsr_gen.sv - directed self-checking bench for lfsr_gen (N=20 Fibonacci and N=4 Galois)
module tb_lfsr_gen;

  logic        clk = 1'b0;
  logic        r, load, en;
  logic [19:0] seed;
  logic [19:0] q, qbar, period;
  logic        out_bit, seed_err, period_done;

  logic        r4, load4, en4;
  logic [3:0]  seed4;
  logic [3:0]  q4, qbar4, period4;
  logic        out_bit4, seed_err4, period_done4;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  lfsr_gen u_fib (
    .clk(clk), .r(r), .load(load), .seed(seed), .en(en),
    .q(q), .qbar(qbar), .out_bit(out_bit), .seed_err(seed_err),
    .period_done(period_done), .period(period)
  );

  lfsr_gen #(.N(4), .POLY(4'b1001), .GALOIS(1'b1), .RESET_SEED(4'h1)) u_gal (
    .clk(clk), .r(r4), .load(load4), .seed(seed4), .en(en4),
    .q(q4), .qbar(qbar4), .out_bit(out_bit4), .seed_err(seed_err4),
    .period_done(period_done4), .period(period4)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    r = 1'b1; load = 1'b0; en = 1'b0; seed = '0;
    r4 = 1'b1; load4 = 1'b0; en4 = 1'b0; seed4 = '0;
    tick();
    r = 1'b0; r4 = 1'b0;
    tests++; if (q !== 20'h00001) begin fails++; $display("FAIL reset_q got=%h exp=00001", q); end
    tests++; if (qbar !== 20'hFFFFE) begin fails++; $display("FAIL reset_qbar got=%h exp=ffffe", qbar); end
    tests++; if (seed_err !== 1'b0 || period_done !== 1'b0 || out_bit !== 1'b0)
      begin fails++; $display("FAIL reset_flags got=%b%b%b exp=000", seed_err, period_done, out_bit); end
    tests++; if (period !== 20'h0) begin fails++; $display("FAIL reset_period got=%h exp=0", period); end
    tests++; if (q4 !== 4'h1 || qbar4 !== 4'hE) begin fails++; $display("FAIL reset_gal got=%h/%h exp=1/e", q4, qbar4); end
  endtask

  task automatic test_fib_step();
    load = 1'b1; seed = 20'h00008; tick();
    tests++; if (q !== 20'h00008) begin fails++; $display("FAIL fib_load got=%h exp=00008", q); end
    load = 1'b0; en = 1'b1; tick();
    tests++; if (q !== 20'h00010 || out_bit !== 1'b0) begin fails++; $display("FAIL fib_step1 got=%h/%b exp=00010/0", q, out_bit); end
    en = 1'b0; load = 1'b1; seed = 20'h80000; tick();
    tests++; if (out_bit !== 1'b1) begin fails++; $display("FAIL fib_outbit got=%b exp=1", out_bit); end
    load = 1'b0; en = 1'b1; tick();
    tests++; if (q !== 20'h00001 || qbar !== 20'hFFFFE) begin fails++; $display("FAIL fib_step2 got=%h/%h exp=00001/ffffe", q, qbar); end
    en = 1'b0;
  endtask

  task automatic test_fib_sequence();
    logic [19:0] exp_tab [0:3];
    exp_tab[0] = 20'h20001; exp_tab[1] = 20'h40002; exp_tab[2] = 20'h80004; exp_tab[3] = 20'h00009;
    load = 1'b1; seed = 20'h00001; tick();
    load = 1'b0; en = 1'b1;
    for (int i = 0; i < 16; i++) tick();
    tests++; if (q !== 20'h10000) begin fails++; $display("FAIL fib_step16 got=%h exp=10000", q); end
    for (int i = 0; i < 4; i++) begin
      tick();
      tests++; if (q !== exp_tab[i]) begin fails++; $display("FAIL fib_step%0d got=%h exp=%h", 17 + i, q, exp_tab[i]); end
    end
    en = 1'b0;
  endtask

  task automatic test_hold();
    en = 1'b0; tick(); tick();
    tests++; if (q !== 20'h00009 || qbar !== 20'hFFFF6) begin fails++; $display("FAIL hold got=%h/%h exp=00009/ffff6", q, qbar); end
  endtask

  task automatic test_zero_seed();
    load = 1'b1; seed = 20'h0; tick();
    tests++; if (q !== 20'h00001 || seed_err !== 1'b1) begin fails++; $display("FAIL zero_seed got=%h/%b exp=00001/1", q, seed_err); end
    load = 1'b0; tick();
    tests++; if (seed_err !== 1'b0 || q !== 20'h00001) begin fails++; $display("FAIL zero_seed_after got=%h/%b exp=00001/0", q, seed_err); end
    load4 = 1'b1; seed4 = 4'h0; tick();
    load4 = 1'b0;
    tests++; if (q4 !== 4'h1 || seed_err4 !== 1'b1) begin fails++; $display("FAIL zero_seed_gal got=%h/%b exp=1/1", q4, seed_err4); end
  endtask

  task automatic test_priority();
    load = 1'b1; en = 1'b1; seed = 20'h00AAA; tick();
    tests++; if (q !== 20'h00AAA) begin fails++; $display("FAIL prio_load_en got=%h exp=00aaa", q); end
    r = 1'b1; load = 1'b1; seed = 20'h00005; tick();
    tests++; if (q !== 20'h00001) begin fails++; $display("FAIL prio_reset_load got=%h exp=00001", q); end
    r = 1'b0; load = 1'b0; en = 1'b0;
  endtask

  task automatic test_back_to_back();
    load = 1'b1; seed = 20'h12345; tick();
    seed = 20'h0; tick();
    tests++; if (q !== 20'h00001 || seed_err !== 1'b1) begin fails++; $display("FAIL b2b_zero got=%h/%b exp=00001/1", q, seed_err); end
    seed = 20'h54321; tick();
    tests++; if (q !== 20'h54321 || seed_err !== 1'b0) begin fails++; $display("FAIL b2b_load got=%h/%b exp=54321/0", q, seed_err); end
    load = 1'b0;
  endtask

  task automatic test_galois();
    logic [3:0] exp_tab [0:14];
    logic       exp_pd;
    logic [3:0] exp_per;
    exp_tab[0] = 4'h2; exp_tab[1] = 4'h4; exp_tab[2] = 4'h8; exp_tab[3] = 4'h3;
    exp_tab[4] = 4'h6; exp_tab[5] = 4'hC; exp_tab[6] = 4'hB; exp_tab[7] = 4'h5;
    exp_tab[8] = 4'hA; exp_tab[9] = 4'h7; exp_tab[10] = 4'hE; exp_tab[11] = 4'hF;
    exp_tab[12] = 4'hD; exp_tab[13] = 4'h9; exp_tab[14] = 4'h1;
    load4 = 1'b1; seed4 = 4'h1; tick();
    load4 = 1'b0; en4 = 1'b1;
    for (int i = 0; i < 15; i++) begin
      tick();
`ifdef LFSR_PERIOD_CHECK_EN
      exp_pd = (i == 14);
`else
      exp_pd = 1'b0;
`endif
      tests++;
      if (q4 !== exp_tab[i] || period_done4 !== exp_pd)
        begin fails++; $display("FAIL gal_step%0d got=%h/%b exp=%h/%b", i + 1, q4, period_done4, exp_tab[i], exp_pd); end
    end
`ifdef LFSR_PERIOD_CHECK_EN
    exp_per = 4'hF;
`else
    exp_per = 4'h0;
`endif
    tests++; if (period4 !== exp_per) begin fails++; $display("FAIL gal_period got=%h exp=%h", period4, exp_per); end
    tick();
    tests++; if (period_done4 !== 1'b0 || q4 !== 4'h2) begin fails++; $display("FAIL gal_pulse_end got=%h/%b exp=2/0", q4, period_done4); end
    // load mid-sequence: measurement restarts, period keeps last value
    en4 = 1'b0; load4 = 1'b1; seed4 = 4'h3; tick();
    load4 = 1'b0; en4 = 1'b1;
    tests++; if (period4 !== exp_per || q4 !== 4'h3) begin fails++; $display("FAIL gal_load_mid got=%h/%h exp=3/%h", q4, period4, exp_per); end
    for (int i = 0; i < 14; i++) begin
      tick();
      tests++; if (period_done4 !== 1'b0) begin fails++; $display("FAIL gal_early_pulse step=%0d got=1 exp=0", i + 1); end
    end
    tick();
    tests++; if (q4 !== 4'h3 || period_done4 !== exp_per[0]) begin fails++; $display("FAIL gal_restart got=%h/%b exp=3/%b", q4, period_done4, exp_per[0]); end
    en4 = 1'b0;
  endtask

  task automatic test_fib_no_early_period();
    int pulses;
    pulses = 0;
    load = 1'b1; seed = 20'h00001; tick();
    load = 1'b0; en = 1'b1;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (period_done === 1'b1) pulses++;
    end
    en = 1'b0;
    tests++; if (pulses != 0) begin fails++; $display("FAIL fib_no_early_period got=%0d exp=0", pulses); end
    r = 1'b1; load = 1'b1; en = 1'b1; tick();
    r = 1'b0; load = 1'b0; en = 1'b0;
    tests++; if (q !== 20'h00001 || period !== 20'h0) begin fails++; $display("FAIL reset_mid got=%h/%h exp=00001/0", q, period); end
  endtask

  initial begin
    test_reset();
    test_fib_step();
    test_fib_sequence();
    test_hold();
    test_zero_seed();
    test_priority();
    test_back_to_back();
    test_galois();
    test_fib_no_early_period();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
